// File: rtl/hs_reset_pkg.sv
// Shared types and helpers for the reset sequencer.
//   rst_seq_state_e : sequencer FSM states
//   calc_cnt_w()    : width of the shared delay/timeout counter
package hs_reset_pkg;

    typedef enum logic [1:0] {
        DELAY    = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2,
        SW_HOLD  = 2'd3
    } rst_seq_state_e;

    // Counter must hold values up to max(delay, timeout) - 1; the +1 keeps
    // the result at least 1 bit wide when both are 1.
    function automatic int calc_cnt_w(input int delay_cycles, input int ack_timeout);
        int m;
        m = (delay_cycles > ack_timeout) ? delay_cycles : ack_timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hs_unit_reset_timer.sv
// Shared up-counter for the reset sequencer (delay, ack timeout, sw hold).
// Ports:
//   clk, aresetn : clock, async active-low reset
//   i_clr        : synchronous clear (wins over i_en)
//   i_en         : count enable
//   o_dly_exp    : counter == DELAY_CYCLES-1
//   o_to_exp     : counter == ACK_TIMEOUT-1 (never asserted when ACK_TIMEOUT==0)
module hs_unit_reset_timer
    import hs_reset_pkg::*;
#(
    parameter int DELAY_CYCLES = 16,
    parameter int ACK_TIMEOUT  = 256,
    parameter int CNT_W        = calc_cnt_w(DELAY_CYCLES, ACK_TIMEOUT)
) (
    input  logic clk,
    input  logic aresetn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_dly_exp,
    output logic o_to_exp
);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_dly_exp = (r_cnt == DLY_LAST);
    assign o_to_exp  = (ACK_TIMEOUT != 0) && (r_cnt == TO_LAST);

endmodule

// File: rtl/hs_unit_reset_sequencer.sv
// Ordered reset release sequencer. Releases stage_rstn[0..N_STAGES-1] one at
// a time, each after a programmable delay, waiting for a per-stage ack (with
// optional timeout) before moving on. sw_rst_req re-runs the whole sequence.
// Ports:
//   clk, aresetn  : clock, async active-low reset (already release-synchronized)
//   sw_rst_req    : warm-reset request, sampled every rising edge
//   stage_ack     : per-stage ready, only the current stage's bit in WAIT_ACK counts
//   stage_rstn    : per-stage active-low resets, thermometer coded
//   seq_done      : all stages released and acked/timed out
//   timeout_err   : sticky, some stage timed out in this sequence
//   cur_stage     : stage being sequenced, N_STAGES when done
module hs_unit_reset_sequencer
    import hs_reset_pkg::*;
#(
    parameter int N_STAGES     = 4,
    parameter int DELAY_CYCLES = 16,
    parameter int ACK_TIMEOUT  = 256
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic                              sw_rst_req,
    input  logic [N_STAGES-1:0]               stage_ack,
    output logic [N_STAGES-1:0]               stage_rstn,
    output logic                              seq_done,
    output logic                              timeout_err,
    output logic [$clog2(N_STAGES+1)-1:0]     cur_stage
);

    localparam int CNT_W = calc_cnt_w(DELAY_CYCLES, ACK_TIMEOUT);
    localparam int SW    = $clog2(N_STAGES + 1);

    localparam logic [N_STAGES-1:0] ONE      = N_STAGES'(1);
    localparam logic [SW-1:0]       LAST_STG = SW'(N_STAGES - 1);
    localparam logic [SW-1:0]       ALL_STG  = SW'(N_STAGES);

    rst_seq_state_e      r_state, w_state_nxt;
    logic [N_STAGES-1:0] r_stage_rstn, w_rstn_nxt;
    logic [SW-1:0]       r_cur_stage, w_cur_nxt;
    logic                r_seq_done, w_done_nxt;
    logic                r_timeout_err, w_err_nxt;

    logic                w_tmr_clr, w_tmr_en;
    logic                w_dly_exp, w_to_exp;
    logic [N_STAGES-1:0] w_cur_onehot;
    logic                w_ack_cur;

    hs_unit_reset_timer #(
        .DELAY_CYCLES (DELAY_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk       (clk),
        .aresetn   (aresetn),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_dly_exp (w_dly_exp),
        .o_to_exp  (w_to_exp)
    );

    // cur_stage is always < N_STAGES outside DONE, so the one-hot is valid
    // wherever it is used.
    assign w_cur_onehot = ONE << r_cur_stage;
    assign w_ack_cur    = |(stage_ack & w_cur_onehot);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= DELAY;
            r_stage_rstn  <= '0;
            r_cur_stage   <= '0;
            r_seq_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_stage_rstn  <= w_rstn_nxt;
            r_cur_stage   <= w_cur_nxt;
            r_seq_done    <= w_done_nxt;
            r_timeout_err <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rstn_nxt  = r_stage_rstn;
        w_cur_nxt   = r_cur_stage;
        w_done_nxt  = r_seq_done;
        w_err_nxt   = r_timeout_err;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;

        if (sw_rst_req) begin
            // Warm reset overrides every other transition, including an ack
            // or release landing on the same edge.
            w_state_nxt = SW_HOLD;
            w_rstn_nxt  = '0;
            w_cur_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_tmr_clr   = 1'b1;
        end else begin
            case (r_state)
                DELAY: begin
                    if (w_dly_exp) begin
                        w_rstn_nxt  = r_stage_rstn | w_cur_onehot;
                        w_tmr_clr   = 1'b1;
                        w_state_nxt = WAIT_ACK;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (w_ack_cur || w_to_exp) begin
                        // An ack on the timeout edge still counts as an ack.
                        if (!w_ack_cur)
                            w_err_nxt = 1'b1;
                        w_tmr_clr = 1'b1;
                        if (r_cur_stage == LAST_STG) begin
                            w_done_nxt  = 1'b1;
                            w_cur_nxt   = ALL_STG;
                            w_state_nxt = DONE;
                        end else begin
                            w_cur_nxt   = r_cur_stage + 1'b1;
                            w_state_nxt = DELAY;
                        end
                    end else begin
                        // With no timeout the counter is frozen so it never wraps.
                        w_tmr_en = (ACK_TIMEOUT != 0);
                    end
                end
                DONE: begin
                    w_tmr_clr = 1'b1;
                end
                SW_HOLD: begin
                    // Only reached with sw_rst_req low here; counts the
                    // post-request quiet period.
                    if (w_dly_exp) begin
                        w_tmr_clr   = 1'b1;
                        w_state_nxt = DELAY;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = DELAY;
                    w_tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    assign stage_rstn  = r_stage_rstn;
    assign seq_done    = r_seq_done;
    assign timeout_err = r_timeout_err;
    assign cur_stage   = r_cur_stage;

endmodule

// File: tb/tb_hs_unit_reset_sequencer.sv
// Scoreboard bench for hs_unit_reset_sequencer (N=4, DELAY=4, TIMEOUT=8).
// The reference model derives release/advance edges from ack latencies:
//   release(0) = start + D - 1, advance(i) = release(i) + min(lat(i), T),
//   release(i+1) = advance(i) + D. Every output change is checked against
//   the next queued event (edge number and values).
module tb_hs_unit_reset_sequencer;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int T  = 8;
    localparam int SW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          aresetn;
    logic          sw_rst_req;
    logic [N-1:0]  stage_ack;
    logic [N-1:0]  stage_rstn;
    logic          seq_done;
    logic          timeout_err;
    logic [SW-1:0] cur_stage;

    always #5 clk = ~clk;

    hs_unit_reset_sequencer #(
        .N_STAGES     (N),
        .DELAY_CYCLES (D),
        .ACK_TIMEOUT  (T)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .sw_rst_req  (sw_rst_req),
        .stage_ack   (stage_ack),
        .stage_rstn  (stage_rstn),
        .seq_done    (seq_done),
        .timeout_err (timeout_err),
        .cur_stage   (cur_stage)
    );

    typedef struct {
        int            edge_n;
        logic [N-1:0]  rstn;
        logic          done;
        logic          err;
        logic [SW-1:0] cur;
    } ev_t;

    ev_t sb[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    int  rel[N];
    int  adv[N];
    int  lat[N];
    bit  act     = 1'b0;
    bit  allhigh = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, a, e, cyc);
        end
    endtask

    // Ack for stage i is presented for the edge release(i)+lat(i); bits of
    // already-finished stages toggle randomly (must be ignored).
    task automatic drive_ack();
        logic [N-1:0] a;
        int k;
        a = '0;
        k = cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (act) begin
                if (allhigh)
                    a[i] = 1'b1;
                else if (lat[i] <= T && k >= rel[i] + lat[i] && k <= adv[i])
                    a[i] = 1'b1;
                else if (k > adv[i] && $urandom_range(1, 0) == 1)
                    a[i] = 1'b1;
            end
        end
        stage_ack = a;
    endtask

    task automatic tick();
        @(negedge clk);
        drive_ack();
    endtask

    task automatic plan(input int r0);
        ev_t  e;
        int   r;
        logic err;
        r   = r0;
        err = 1'b0;
        for (int i = 0; i < N; i++) begin
            rel[i] = r;
            adv[i] = r + ((lat[i] < T) ? lat[i] : T);
            e.edge_n = r;
            e.rstn   = N'((1 << (i + 1)) - 1);
            e.done   = 1'b0;
            e.err    = err;
            e.cur    = SW'(i);
            sb.push_back(e);
            if (lat[i] > T) err = 1'b1;
            e.edge_n = adv[i];
            e.err    = err;
            e.cur    = SW'(i + 1);
            e.done   = (i == N - 1);
            sb.push_back(e);
            r = adv[i] + D;
        end
    endtask

    task automatic set_lat(input int v);
        for (int i = 0; i < N; i++) lat[i] = v;
    endtask

    task automatic rand_lat();
        for (int i = 0; i < N; i++)
            lat[i] = ($urandom_range(4, 0) == 0) ? 99 : int'($urandom_range(10, 1));
    endtask

    task automatic wait_done();
        bit anyto;
        anyto = 1'b0;
        for (int i = 0; i < N; i++) if (lat[i] > T) anyto = 1'b1;
        while (cyc < adv[N-1]) tick();
        #1;
        chk("seq_done_final", int'(seq_done), 1);
        chk("timeout_err_final", int'(timeout_err), int'(anyto));
        chk("cur_stage_final", int'(cur_stage), N);
    endtask

    // Asserts sw_rst_req for p edges; returns the first edge sampling it low.
    task automatic sw_reset(input int p, output int e_low);
        int  e0;
        ev_t z;
        sw_rst_req = 1'b1;
        e0 = cyc + 1;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].edge_n >= e0) sb.delete(i);
        if (e0 > rel[0]) begin
            z.edge_n = e0; z.rstn = '0; z.done = 1'b0; z.err = 1'b0; z.cur = '0;
            sb.push_back(z);
        end
        tick();
        #1;
        chk("sw_rstn_clear", int'(stage_rstn), 0);
        chk("sw_cur_clear", int'(cur_stage), 0);
        chk("sw_err_clear", int'(timeout_err), 0);
        repeat (p - 1) tick();
        sw_rst_req = 1'b0;
        e_low = cyc + 1;
    endtask

    // Monitor: any change of the observed outputs must match the next event.
    initial begin
        logic [N+SW+1:0] prev, cur_v;
        ev_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur_v = {stage_rstn, seq_done, timeout_err, cur_stage};
            if (!aresetn) begin
                prev = cur_v;
            end else if (cur_v !== prev) begin
                prev = cur_v;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: edge %0d got rstn=%b done=%b err=%b cur=%0d, required no change",
                             cyc, stage_rstn, seq_done, timeout_err, cur_stage);
                end else begin
                    e = sb.pop_front();
                    if (e.edge_n != cyc || e.rstn !== stage_rstn || e.done !== seq_done ||
                        e.err !== timeout_err || e.cur !== cur_stage) begin
                        errors++;
                        $display("FAIL event: got edge %0d rstn=%b done=%b err=%b cur=%0d, required edge %0d rstn=%b done=%b err=%b cur=%0d",
                                 cyc, stage_rstn, seq_done, timeout_err, cur_stage,
                                 e.edge_n, e.rstn, e.done, e.err, e.cur);
                    end
                end
            end
        end
    end

    initial begin
        int e;
        int cut;
        aresetn    = 1'b0;
        sw_rst_req = 1'b0;
        stage_ack  = '0;
        repeat (3) tick();
        #1;
        chk("rst_stage_rstn", int'(stage_rstn), 0);
        chk("rst_seq_done", int'(seq_done), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_cur_stage", int'(cur_stage), 0);

        // Power-up, acks 2 cycles after each release.
        set_lat(2);
        aresetn = 1'b1;
        act     = 1'b1;
        plan(cyc + 1 + D - 1);
        wait_done();

        // Stage 1 never acks -> timeout path.
        sw_reset(2, e);
        set_lat(2); lat[1] = 99;
        plan(e + 2 * D - 1);
        wait_done();

        // Warm reset clears the sticky error.
        sw_reset(3, e);
        set_lat(2);
        plan(e + 2 * D - 1);
        wait_done();

        // Acks held high from reset.
        tick();
        aresetn = 1'b0;
        act     = 1'b0;
        sb.delete();
        tick();
        aresetn = 1'b1;
        act     = 1'b1;
        allhigh = 1'b1;
        set_lat(1);
        plan(cyc + 1 + D - 1);
        wait_done();
        allhigh = 1'b0;

        // Async abort in the middle of stage 2's WAIT_ACK.
        tick();
        aresetn = 1'b0;
        act     = 1'b0;
        sb.delete();
        tick();
        aresetn = 1'b1;
        act     = 1'b1;
        set_lat(2); lat[2] = 5;
        plan(cyc + 1 + D - 1);
        while (cyc < rel[2] + 1) tick();
        @(posedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("abort_stage_rstn", int'(stage_rstn), 0);
        chk("abort_seq_done", int'(seq_done), 0);
        chk("abort_cur_stage", int'(cur_stage), 0);
        sb.delete();
        act = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        act     = 1'b1;
        set_lat(2);
        plan(cyc + 1 + D - 1);
        wait_done();

        // sw_rst_req on the same edge as stage 1's ack.
        sw_reset(1, e);
        set_lat(2);
        plan(e + 2 * D - 1);
        while (cyc < adv[1] - 1) tick();
        sw_reset(2, e);
        set_lat(2);
        plan(e + 2 * D - 1);
        wait_done();

        // Randomized runs, some interrupted by a warm reset mid-sequence.
        for (int it = 0; it < 8; it++) begin
            sw_reset(int'($urandom_range(3, 1)), e);
            rand_lat();
            plan(e + 2 * D - 1);
            if ($urandom_range(2, 0) == 0) begin
                cut = rel[0] - 1 + int'($urandom_range(adv[N-1] - rel[0] + 1, 0));
                while (cyc < cut - 1) tick();
            end else begin
                wait_done();
            end
        end
        sw_reset(1, e);
        set_lat(3);
        plan(e + 2 * D - 1);
        wait_done();

        repeat (5) tick();
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1);
    end

endmodule
